// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address width, known device addresses
// and the bus arbiter state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    localparam logic [I2C_ADDR_W-1:0] AHT20_ADDR = 7'h38;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Round-robin priority encoder: first eligible index at or above
// the pointer, wrapping back to zero.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    // Scan NUM_REQ slots starting at ptr, keep the first hit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && eligible[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_master stream interface between NUM_REQ controllers,
// one whole transaction per grant, with a hold watchdog.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int HOLD_MAX = 8000000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] r_cmd_address,
    input  logic [NUM_REQ-1:0]            r_cmd_start,
    input  logic [NUM_REQ-1:0]            r_cmd_read,
    input  logic [NUM_REQ-1:0]            r_cmd_write,
    input  logic [NUM_REQ-1:0]            r_cmd_write_multiple,
    input  logic [NUM_REQ-1:0]            r_cmd_stop,
    input  logic [NUM_REQ-1:0]            r_cmd_valid,
    output logic [NUM_REQ-1:0]            r_cmd_ready,
    input  logic [8*NUM_REQ-1:0]          r_wdata,
    input  logic [NUM_REQ-1:0]            r_wvalid,
    input  logic [NUM_REQ-1:0]            r_wlast,
    output logic [NUM_REQ-1:0]            r_wready,
    output logic [7:0]                    r_rdata,
    output logic                          r_rlast,
    output logic [NUM_REQ-1:0]            r_rvalid,
    input  logic [NUM_REQ-1:0]            r_rready,
    output logic [NUM_REQ-1:0]            r_missed_ack,
    output logic [I2C_ADDR_W-1:0]         m_cmd_address,
    output logic                          m_cmd_start,
    output logic                          m_cmd_read,
    output logic                          m_cmd_write,
    output logic                          m_cmd_write_multiple,
    output logic                          m_cmd_stop,
    output logic                          m_cmd_valid,
    input  logic                          m_cmd_ready,
    output logic [7:0]                    m_wdata,
    output logic                          m_wvalid,
    output logic                          m_wlast,
    input  logic                          m_wready,
    input  logic [7:0]                    m_rdata,
    input  logic                          m_rvalid,
    input  logic                          m_rlast,
    output logic                          m_rready,
    input  logic                          m_busy,
    input  logic                          m_missed_ack,
    output logic [ID_W-1:0]               owner,
    output logic                          bus_granted,
    output logic                          timeout
);

    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] lockout_q, lockout_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;
    logic               owner_req;
    logic [ID_W-1:0]    owner_next;

    assign eligible = req & ~lockout_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // Owner's request line and the pointer slot just past the owner.
    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_req = req[i];
            end
        end
        if (owner_q == ID_W'(NUM_REQ - 1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + ID_W'(1);
        end
    end

    // Arbiter FSM: grant, hold with watchdog, drain until master idle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        lockout_d = lockout_q & req;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found && !m_busy) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (pick_idx == ID_W'(i));
                    end
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!owner_req) begin
                    state_d = ST_DRAIN;
                    gnt_d   = '0;
                    rr_d    = owner_next;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_DRAIN;
                    gnt_d     = '0;
                    rr_d      = owner_next;
                    timeout_d = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (owner_q == ID_W'(i)) begin
                            lockout_d[i] = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!m_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            lockout_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            lockout_q <= lockout_d;
            timeout_q <= timeout_d;
        end
    end

    // Stream routing: owner only while granted, discard reads in drain.
    always_comb begin
        m_cmd_address        = '0;
        m_cmd_start          = 1'b0;
        m_cmd_read           = 1'b0;
        m_cmd_write          = 1'b0;
        m_cmd_write_multiple = 1'b0;
        m_cmd_stop           = 1'b0;
        m_cmd_valid          = 1'b0;
        m_wdata              = '0;
        m_wvalid             = 1'b0;
        m_wlast              = 1'b0;
        m_rready             = 1'b0;
        r_cmd_ready          = '0;
        r_wready             = '0;
        r_rvalid             = '0;
        r_missed_ack         = '0;
        if (state_q == ST_GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == ID_W'(i)) begin
                    m_cmd_address        = r_cmd_address[i*I2C_ADDR_W +: I2C_ADDR_W];
                    m_cmd_start          = r_cmd_start[i];
                    m_cmd_read           = r_cmd_read[i];
                    m_cmd_write          = r_cmd_write[i];
                    m_cmd_write_multiple = r_cmd_write_multiple[i];
                    m_cmd_stop           = r_cmd_stop[i];
                    m_cmd_valid          = r_cmd_valid[i];
                    m_wdata              = r_wdata[i*8 +: 8];
                    m_wvalid             = r_wvalid[i];
                    m_wlast              = r_wlast[i];
                    m_rready             = r_rready[i];
                    r_cmd_ready[i]       = m_cmd_ready;
                    r_wready[i]          = m_wready;
                    r_rvalid[i]          = m_rvalid;
                    r_missed_ack[i]      = m_missed_ack;
                end
            end
        end else if (state_q == ST_DRAIN) begin
            m_rready = 1'b1;
        end
    end

    assign r_rdata     = m_rdata;
    assign r_rlast     = m_rlast;
    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign bus_granted = (state_q == ST_GRANT);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: two requesters, short watchdog.
module tb_i2c_bus_arbiter;

    localparam int N = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [7*N-1:0] r_cmd_address;
    logic [N-1:0]  r_cmd_start, r_cmd_read, r_cmd_write;
    logic [N-1:0]  r_cmd_write_multiple, r_cmd_stop, r_cmd_valid;
    logic [N-1:0]  r_cmd_ready;
    logic [8*N-1:0] r_wdata;
    logic [N-1:0]  r_wvalid, r_wlast, r_wready;
    logic [7:0]    r_rdata;
    logic          r_rlast;
    logic [N-1:0]  r_rvalid, r_rready, r_missed_ack;
    logic [6:0]    m_cmd_address;
    logic          m_cmd_start, m_cmd_read, m_cmd_write;
    logic          m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
    logic          m_cmd_ready;
    logic [7:0]    m_wdata;
    logic          m_wvalid, m_wlast, m_wready;
    logic [7:0]    m_rdata;
    logic          m_rvalid, m_rlast, m_rready;
    logic          m_busy, m_missed_ack;
    logic [0:0]    owner;
    logic          bus_granted;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    i2c_bus_arbiter #(
        .NUM_REQ  (2),
        .ID_W     (1),
        .HOLD_MAX (16)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req                  (req),
        .gnt                  (gnt),
        .r_cmd_address        (r_cmd_address),
        .r_cmd_start          (r_cmd_start),
        .r_cmd_read           (r_cmd_read),
        .r_cmd_write          (r_cmd_write),
        .r_cmd_write_multiple (r_cmd_write_multiple),
        .r_cmd_stop           (r_cmd_stop),
        .r_cmd_valid          (r_cmd_valid),
        .r_cmd_ready          (r_cmd_ready),
        .r_wdata              (r_wdata),
        .r_wvalid             (r_wvalid),
        .r_wlast              (r_wlast),
        .r_wready             (r_wready),
        .r_rdata              (r_rdata),
        .r_rlast              (r_rlast),
        .r_rvalid             (r_rvalid),
        .r_rready             (r_rready),
        .r_missed_ack         (r_missed_ack),
        .m_cmd_address        (m_cmd_address),
        .m_cmd_start          (m_cmd_start),
        .m_cmd_read           (m_cmd_read),
        .m_cmd_write          (m_cmd_write),
        .m_cmd_write_multiple (m_cmd_write_multiple),
        .m_cmd_stop           (m_cmd_stop),
        .m_cmd_valid          (m_cmd_valid),
        .m_cmd_ready          (m_cmd_ready),
        .m_wdata              (m_wdata),
        .m_wvalid             (m_wvalid),
        .m_wlast              (m_wlast),
        .m_wready             (m_wready),
        .m_rdata              (m_rdata),
        .m_rvalid             (m_rvalid),
        .m_rlast              (m_rlast),
        .m_rready             (m_rready),
        .m_busy               (m_busy),
        .m_missed_ack         (m_missed_ack),
        .owner                (owner),
        .bus_granted          (bus_granted),
        .timeout              (timeout)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0;
        r_cmd_address = '0;
        r_cmd_start = '0;
        r_cmd_read = '0;
        r_cmd_write = '0;
        r_cmd_write_multiple = '0;
        r_cmd_stop = '0;
        r_cmd_valid = '0;
        r_wdata = '0;
        r_wvalid = '0;
        r_wlast = '0;
        r_rready = '0;
        m_cmd_ready = 1'b0;
        m_wready = 1'b0;
        m_rdata = '0;
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        m_busy = 1'b0;
        m_missed_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 00", gnt);
        end
        checks++;
        if ({owner, bus_granted, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b want 000", {owner, bus_granted, timeout});
        end
        checks++;
        if ({m_cmd_valid, m_wvalid, m_rready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mvalids: got %b want 000", {m_cmd_valid, m_wvalid, m_rready});
        end
    endtask

    task automatic test_single_owner();
        do_reset();
        req = 2'b01;
        step();
        checks++;
        if ({gnt, owner, bus_granted} !== 4'b01_0_1) begin
            errors++;
            $display("FAIL single_grant: got %b want 0101", {gnt, owner, bus_granted});
        end
        r_cmd_address = {7'h11, 7'h38};
        r_cmd_valid = 2'b11;
        r_cmd_start = 2'b01;
        m_cmd_ready = 1'b1;
        r_wdata = {8'h5a, 8'ha5};
        r_wvalid = 2'b01;
        m_wready = 1'b1;
        m_missed_ack = 1'b1;
        #1;
        checks++;
        if ({m_cmd_address, m_cmd_valid, m_cmd_start} !== {7'h38, 2'b11}) begin
            errors++;
            $display("FAIL single_cmd: got %h/%b%b want 38/11", m_cmd_address, m_cmd_valid, m_cmd_start);
        end
        checks++;
        if (r_cmd_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_cmd_ready: got %b want 01", r_cmd_ready);
        end
        checks++;
        if ({m_wdata, m_wvalid, r_wready, r_missed_ack} !== {8'ha5, 1'b1, 2'b01, 2'b01}) begin
            errors++;
            $display("FAIL single_wdata: got %h %b %b %b want a5 1 01 01", m_wdata, m_wvalid, r_wready, r_missed_ack);
        end
        m_cmd_ready = 1'b0;
        #1;
        checks++;
        if (r_cmd_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_ready_follow: got %b want 00", r_cmd_ready);
        end
        req = 2'b00;
        step();
        checks++;
        if ({gnt, bus_granted, m_cmd_valid, m_rready} !== 5'b00_0_0_1) begin
            errors++;
            $display("FAIL single_drain: got %b want 00001", {gnt, bus_granted, m_cmd_valid, m_rready});
        end
        step();
    endtask

    task automatic test_contention();
        do_reset();
        req = 2'b11;
        step();
        checks++;
        if ({gnt, owner} !== 3'b01_0) begin
            errors++;
            $display("FAIL cont_first: got %b want 010", {gnt, owner});
        end
        m_busy = 1'b1;
        req = 2'b10;
        step();
        step();
        checks++;
        if ({gnt, bus_granted} !== 3'b00_0) begin
            errors++;
            $display("FAIL cont_busy_drain: got %b want 000", {gnt, bus_granted});
        end
        m_busy = 1'b0;
        step();
        step();
        checks++;
        if ({gnt, owner} !== 3'b10_1) begin
            errors++;
            $display("FAIL cont_second: got %b want 101", {gnt, owner});
        end
        req = 2'b00;
        step();
        step();
        req = 2'b11;
        step();
        checks++;
        if ({gnt, owner} !== 3'b01_0) begin
            errors++;
            $display("FAIL cont_rr_wrap: got %b want 010", {gnt, owner});
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_busy_holdoff();
        do_reset();
        m_busy = 1'b1;
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== 2'b00) begin
                errors++;
                $display("FAIL holdoff_wait%0d: got %b want 00", i, gnt);
            end
        end
        m_busy = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL holdoff_grant: got %b want 01", gnt);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 2'b10;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
        end
        checks++;
        if ({gnt, timeout} !== 3'b10_0) begin
            errors++;
            $display("FAIL wd_before: got %b want 100", {gnt, timeout});
        end
        step();
        checks++;
        if ({gnt, timeout, bus_granted} !== 4'b00_1_0) begin
            errors++;
            $display("FAIL wd_fire: got %b want 0010", {gnt, timeout, bus_granted});
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse: got %b want 0", timeout);
        end
        step();
        step();
        step();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL wd_lockout: got %b want 00", gnt);
        end
        req = 2'b00;
        step();
        req = 2'b10;
        step();
        checks++;
        if ({gnt, owner} !== 3'b10_1) begin
            errors++;
            $display("FAIL wd_regrant: got %b want 101", {gnt, owner});
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_release_wins();
        do_reset();
        req = 2'b01;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
        end
        req = 2'b00;
        step();
        checks++;
        if ({gnt, timeout} !== 3'b00_0) begin
            errors++;
            $display("FAIL release_wins: got %b want 000", {gnt, timeout});
        end
        step();
    endtask

    task automatic test_read_isolation();
        do_reset();
        req = 2'b10;
        step();
        r_rready = 2'b11;
        m_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_rdata = 8'h40 + 8'(i);
            m_rlast = (i == 5);
            m_rvalid = 1'b1;
            #1;
            checks++;
            if ({r_rvalid, r_rdata, r_rlast, m_rready} !== {2'b10, 8'h40 + 8'(i), (i == 5), 1'b1}) begin
                errors++;
                $display("FAIL read_byte%0d: got %b %h %b %b", i, r_rvalid, r_rdata, r_rlast, m_rready);
            end
            step();
        end
        r_rready = 2'b01;
        #1;
        checks++;
        if (m_rready !== 1'b0) begin
            errors++;
            $display("FAIL read_rready_route: got %b want 0", m_rready);
        end
        req = 2'b00;
        step();
        checks++;
        if ({m_rready, r_rvalid, m_cmd_valid} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL read_drain: got %b want 1000", {m_rready, r_rvalid, m_cmd_valid});
        end
        m_busy = 1'b0;
        m_rvalid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        step();
        req = 2'b10;
        step();
        r_cmd_valid = 2'b11;
        r_wvalid = 2'b11;
        reset = 1'b1;
        step();
        checks++;
        if ({gnt, bus_granted, timeout, m_cmd_valid, m_wvalid} !== 6'b00_0000) begin
            errors++;
            $display("FAIL rst_mid: got %b want 000000", {gnt, bus_granted, timeout, m_cmd_valid, m_wvalid});
        end
        reset = 1'b0;
        r_cmd_valid = 2'b00;
        r_wvalid = 2'b00;
        req = 2'b11;
        step();
        checks++;
        if ({gnt, owner} !== 3'b01_0) begin
            errors++;
            $display("FAIL rst_mid_rr: got %b want 010", {gnt, owner});
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_owner();
        test_contention();
        test_busy_holdoff();
        test_watchdog();
        test_release_wins();
        test_read_isolation();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
